// File: rtl/buf_ctrl_pkg.sv
// Shared definitions for the BRAM buffer-pool fill controller.
// Holds the FSM state type, the default pool geometry and the helper that maps
// a port group to the index of its first buffer.
package buf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int X_MAC_DEF    = 4;
  localparam int X_MESH_DEF   = 16;
  localparam int ADDR_LEN_DEF = 13;
  localparam int DATA_LEN_DEF = 32;

  localparam int BUFFER_NUM = X_MAC_DEF * X_MESH_DEF;
  localparam int IN_WIDTH   = X_MAC_DEF * DATA_LEN_DEF;

  // Index of the first buffer belonging to port group grp.
  function automatic int grp_base(input int grp, input int x_mac);
    return grp * x_mac;
  endfunction

endpackage

// File: rtl/buf_wr_addr_gen.sv
// Address generator for the buffer-pool fill stage.
// Walks the port groups round-robin; the per-buffer address advances each time
// the group counter wraps. Flags the terminal beat of a fill of len addresses.
// Optional feature macro: BUFWR_BASE_ADDR_EN (adds a base address captured at load).
import buf_ctrl_pkg::*;

module buf_wr_addr_gen #(
  parameter int X_MESH   = 16,
  parameter int ADDR_LEN = 13,
  localparam int GW      = (X_MESH > 1) ? $clog2(X_MESH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ADDR_LEN:0]   len,
`ifdef BUFWR_BASE_ADDR_EN
  input  logic [ADDR_LEN-1:0] base_addr,
`endif
  input  logic                adv,
  output logic [GW-1:0]       grp,
  output logic [ADDR_LEN-1:0] wr_addr,
  output logic                last
);

  localparam logic [GW-1:0]       LAST_GRP = GW'(X_MESH - 1);
  localparam logic [GW-1:0]       GRP_ONE  = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_LEN-1:0] ADR_ONE  = {{(ADDR_LEN-1){1'b0}}, 1'b1};
  localparam logic [ADDR_LEN:0]   LEN_ONE  = {{ADDR_LEN{1'b0}}, 1'b1};

  logic [ADDR_LEN:0]   len_r;
  logic [ADDR_LEN-1:0] adr_r;
  logic [GW-1:0]       grp_r;
`ifdef BUFWR_BASE_ADDR_EN
  logic [ADDR_LEN-1:0] base_r;
`endif

  // Group/address counters: cleared and len captured at load, stepped per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r <= {(ADDR_LEN+1){1'b0}};
      adr_r <= {ADDR_LEN{1'b0}};
      grp_r <= {GW{1'b0}};
    end else if (load) begin
      len_r <= len;
      adr_r <= {ADDR_LEN{1'b0}};
      grp_r <= {GW{1'b0}};
    end else if (adv) begin
      if (grp_r == LAST_GRP) begin
        grp_r <= {GW{1'b0}};
        adr_r <= adr_r + ADR_ONE;
      end else begin
        grp_r <= grp_r + GRP_ONE;
      end
    end
  end

`ifdef BUFWR_BASE_ADDR_EN
  // Base address is latched together with len so it stays fixed for the whole fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r <= {ADDR_LEN{1'b0}};
    end else if (load) begin
      base_r <= base_addr;
    end
  end

  assign wr_addr = base_r + adr_r;
`else
  assign wr_addr = adr_r;
`endif

  // len-1 is only meaningful for len>=1; a len of 0 never enters the fill state.
  assign grp  = grp_r;
  assign last = (grp_r == LAST_GRP) && ({1'b0, adr_r} == (len_r - LEN_ONE));

endmodule

// File: rtl/buffer_write_ctrl.sv
// Upstream fill stage for the X_MAC x X_MESH BRAM buffer pool.
// Accepts a valid/ready stream of X_MAC-word beats and writes each beat into one
// port group of the pool via port A, groups visited round-robin.
// Optional feature macro: BUFWR_BASE_ADDR_EN (adds base_addr input, address offset mod 2**ADDR_LEN).
import buf_ctrl_pkg::*;

module buffer_write_ctrl #(
  parameter int X_MAC    = X_MAC_DEF,
  parameter int X_MESH   = X_MESH_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  localparam int NBUF    = X_MAC * X_MESH,
  localparam int DW      = NBUF * DATA_LEN,
  localparam int AW      = NBUF * ADDR_LEN,
  localparam int INW     = X_MAC * DATA_LEN,
  localparam int GW      = (X_MESH > 1) ? $clog2(X_MESH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_LEN:0]   len,
`ifdef BUFWR_BASE_ADDR_EN
  input  logic [ADDR_LEN-1:0] base_addr,
`endif
  output logic                busy,
  output logic                done,
  input  logic [INW-1:0]      s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [DW-1:0]       dina,
  output logic [AW-1:0]       addra,
  output logic [NBUF-1:0]     wea
);

  state_t              state_r;
  logic                busy_r;
  logic                done_r;
  logic                last_r;
  logic [DW-1:0]       dina_r;
  logic [AW-1:0]       addra_r;
  logic [NBUF-1:0]     wea_r;

  logic                hs_s;
  logic                load_s;
  logic                last_s;
  logic [GW-1:0]       grp_s;
  logic [ADDR_LEN-1:0] wr_addr_s;

  // last_r marks that the terminal beat was taken: stop accepting, let its write land, then DONE.
  assign s_ready = (state_r == FILL) && !last_r;
  assign hs_s    = s_valid && s_ready;
  assign load_s  = (state_r == IDLE) && start;

  buf_wr_addr_gen #(
    .X_MESH   (X_MESH),
    .ADDR_LEN (ADDR_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .len       (len),
`ifdef BUFWR_BASE_ADDR_EN
    .base_addr (base_addr),
`endif
    .adv       (hs_s),
    .grp       (grp_s),
    .wr_addr   (wr_addr_s),
    .last      (last_s)
  );

  // Control FSM with registered busy/done; DONE is entered one cycle after the final write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          last_r <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            if (len == {(ADDR_LEN+1){1'b0}}) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= FILL;
              done_r  <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        FILL: begin
          busy_r <= 1'b1;
          if (last_r) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            last_r  <= 1'b0;
          end else if (hs_s && last_s) begin
            last_r <= 1'b1;
            done_r <= 1'b0;
          end else begin
            done_r <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          last_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Port-A write register: one group write per accepted beat; data/address hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea_r   <= {NBUF{1'b0}};
      dina_r  <= {DW{1'b0}};
      addra_r <= {AW{1'b0}};
    end else begin
      wea_r <= {NBUF{1'b0}};
      if (hs_s) begin
        for (int g = 0; g < X_MESH; g++) begin
          if (grp_s == GW'(g)) begin
            for (int k = 0; k < X_MAC; k++) begin
              wea_r[grp_base(g, X_MAC) + k] <= 1'b1;
              dina_r[(grp_base(g, X_MAC) + k)*DATA_LEN +: DATA_LEN]  <= s_data[k*DATA_LEN +: DATA_LEN];
              addra_r[(grp_base(g, X_MAC) + k)*ADDR_LEN +: ADDR_LEN] <= wr_addr_s;
            end
          end
        end
      end
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign wea   = wea_r;
  assign dina  = dina_r;
  assign addra = addra_r;

endmodule

// File: tb/tb_buffer_write_ctrl.sv
// Self-checking bench for buffer_write_ctrl with a small pool (4 groups x 2 kernels,
// 3-bit addresses). A beat-level reference model predicts each write, the done/busy
// timing and the final contents of every buffer.
module tb_buffer_write_ctrl;

  localparam int X_MAC    = 2;
  localparam int X_MESH   = 4;
  localparam int ADDR_LEN = 3;
  localparam int DATA_LEN = 8;
  localparam int NBUF     = X_MAC * X_MESH;
  localparam int DEPTH    = 1 << ADDR_LEN;
  localparam int IN_W     = X_MAC * DATA_LEN;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [ADDR_LEN:0]        len;
  logic [ADDR_LEN-1:0]      base_addr;
  logic                     busy, done;
  logic [IN_W-1:0]          s_data;
  logic                     s_valid, s_ready;
  logic [NBUF*DATA_LEN-1:0] dina;
  logic [NBUF*ADDR_LEN-1:0] addra;
  logic [NBUF-1:0]          wea;

  buffer_write_ctrl #(
    .X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
`ifdef BUFWR_BASE_ADDR_EN
    .base_addr(base_addr),
`endif
    .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dina(dina), .addra(addra), .wea(wea)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Shadow pools: one filled from the model, one from what the DUT drives on port A.
  logic [DATA_LEN-1:0] mdl_mem [NBUF][DEPTH];
  logic [DATA_LEN-1:0] dut_mem [NBUF][DEPTH];

  // Reference model state (beat level).
  bit            busy_m, rdy_m, done_due, pend_wr, pend_last;
  int            beats, total, base_m, pend_grp, pend_adr, done_count;
  logic [IN_W-1:0] pend_data;

  // Monitor: check outputs against the model, then advance the model by one cycle.
  always @(negedge clk) begin : mon
    logic [NBUF-1:0] exp_wea;
    bit nd, hs, was_busy;
    if (rst) begin
      busy_m = 0; rdy_m = 0; done_due = 0; pend_wr = 0; pend_last = 0; beats = 0;
    end else begin
      exp_wea = {NBUF{1'b0}};
      if (pend_wr)
        for (int k = 0; k < X_MAC; k++) exp_wea[pend_grp*X_MAC + k] = 1'b1;
      chk("wea", 64'(wea), 64'(exp_wea));
      chk("done", 64'(done), 64'(done_due));
      chk("busy", 64'(busy), 64'(busy_m));
      chk("s_ready", 64'(s_ready), 64'(rdy_m));
      for (int b = 0; b < NBUF; b++)
        if (wea[b]) dut_mem[b][addra[b*ADDR_LEN +: ADDR_LEN]] = dina[b*DATA_LEN +: DATA_LEN];
      if (pend_wr) begin
        chk("addra", 64'(addra[(pend_grp*X_MAC)*ADDR_LEN +: ADDR_LEN]), 64'(pend_adr));
        for (int k = 0; k < X_MAC; k++)
          mdl_mem[pend_grp*X_MAC + k][pend_adr] = pend_data[k*DATA_LEN +: DATA_LEN];
      end
      // Advance the model.
      nd = pend_wr && pend_last;
      was_busy = busy_m;
      if (done_due) busy_m = 0;
      hs = rdy_m && s_valid;
      pend_wr = hs;
      pend_last = 0;
      if (hs) begin
        pend_grp  = beats % X_MESH;
        pend_adr  = (base_m + beats / X_MESH) % DEPTH;
        pend_data = s_data;
        beats++;
        pend_last = (beats == total);
        if (beats == total) rdy_m = 0;
      end
      if (start && !was_busy) begin
        busy_m = 1;
        total  = int'(len) * X_MESH;
        beats  = 0;
`ifdef BUFWR_BASE_ADDR_EN
        base_m = int'(base_addr);
`else
        base_m = 0;
`endif
        if (len == 0) nd = 1;
        else rdy_m = 1;
      end
      done_due = nd;
      if (nd) done_count++;
    end
  end

  task automatic cmp_mem();
    for (int b = 0; b < NBUF; b++)
      for (int a = 0; a < DEPTH; a++)
        chk($sformatf("ram b%0d a%0d", b, a), 64'(dut_mem[b][a]), 64'(mdl_mem[b][a]));
  endtask

  // One fill: start with ln, stream beats with pct% valid, optional mid-fill start pulse
  // or async reset after abort_at beats.
  task automatic run_fill(input int ln, input int pct, input int base, input bit mid_start,
                          input int abort_at);
    int dc0, cyc;
    bit fin;
    dc0 = done_count;
    @(posedge clk); #1;
    start = 1'b1; len = (ADDR_LEN+1)'(ln); base_addr = ADDR_LEN'(base);
    @(posedge clk); #1;
    start = 1'b0;
    fin = 0; cyc = 0;
    while (!fin && cyc < 500) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = IN_W'($urandom);
      start   = (mid_start && cyc == 5);
      @(posedge clk);
      cyc++;
      if (abort_at > 0 && beats >= abort_at) begin
        #3 rst = 1'b1;
        #1;
        chk("abort wea", 64'(wea), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b0; start = 1'b0;
        @(negedge clk); @(posedge clk);
        #3 rst = 1'b0;
        fin = 1;
      end else begin
        #1;
        if (done_count != dc0) fin = 1;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    chk("timeout", 64'(fin), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    if (abort_at == 0) begin
      chk("beats", 64'(beats), 64'(ln * X_MESH));
      cmp_mem();
    end
  endtask

  initial begin
    for (int b = 0; b < NBUF; b++)
      for (int a = 0; a < DEPTH; a++) begin
        mdl_mem[b][a] = '0;
        dut_mem[b][a] = '0;
      end
    rst = 1'b1; start = 1'b0; len = '0; base_addr = '0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst wea", 64'(wea), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst s_ready", 64'(s_ready), 64'd0);
    chk("rst dina", 64'(dina), 64'd0);
    chk("rst addra", 64'(addra), 64'd0);
    #2 rst = 1'b0;

    run_fill(3, 100, 0, 0, 0);   // gap-free, 12 writes
    run_fill(5, 50, 0, 0, 0);    // random valid gaps
    run_fill(0, 100, 0, 0, 0);   // empty fill
    run_fill(4, 100, 0, 0, 7);   // async reset after 7 beats
    run_fill(2, 100, 0, 0, 0);   // restart from group 0, address 0
    run_fill(8, 70, 0, 0, 0);    // full depth, address wraps only on terminal beat
`ifdef BUFWR_BASE_ADDR_EN
    run_fill(2, 100, DEPTH - 1, 0, 0);  // base at top, address wraps to 0
`endif
    run_fill(5, 100, 0, 1, 0);   // start pulsed during fill
    for (int i = 0; i < 3; i++)
      run_fill($urandom_range(8, 1), 60, $urandom_range(DEPTH - 1, 0), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
